// File: rtl/y86_pkg.sv
// Shared Y86 constants: instruction codes, status codes, register IDs and
// condition-code bit positions used by the execute-stage issue logic.
package y86_pkg;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Status codes
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   // Register ID meaning "no register"
   localparam logic [3:0] REG_NONE = 4'hF;

   // Condition-code bit positions within {ZF,SF,OF}
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   // Reset value of the condition codes: ZF set, SF/OF clear
   localparam logic [2:0] CC_RESET = 3'b100;

   // Register IDs carried through the E register
   typedef struct packed {
      logic [3:0] dst_e;
      logic [3:0] dst_m;
      logic [3:0] src_a;
      logic [3:0] src_b;
   } reg_ids_t;

   localparam reg_ids_t REG_IDS_NONE = '{REG_NONE, REG_NONE, REG_NONE, REG_NONE};

endpackage

// File: rtl/cc_reg.sv
// Condition-code register {ZF,SF,OF}. Written by the instruction currently
// in E; bubbles never write. Optional feature macro EXEC_ISSUE_STAT_SQUASH_EN
// additionally blocks the write while an exception sits in M or W.
module cc_reg
   import y86_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       set_cc,
   input  logic       e_valid,
   input  logic [2:0] new_cc,
   input  logic [2:0] m_stat,
   input  logic [2:0] w_stat,
   output logic [2:0] cc
);

   logic wr_en;

`ifdef EXEC_ISSUE_STAT_SQUASH_EN
   // An older instruction that faulted must not see its successor's flags change
   assign wr_en = set_cc & e_valid & (m_stat == STAT_AOK) & (w_stat == STAT_AOK);
`else
   // Stat inputs only matter for the squash variant
   logic unused_stat;
   assign unused_stat = ^{m_stat, w_stat};
   assign wr_en = set_cc & e_valid;
`endif

   // Reset wins over any write pending in the same cycle
   always_ff @(posedge clock) begin
      if (reset)
         cc <= CC_RESET;
      else if (wr_en)
         cc <= new_cc;
   end

endmodule

// File: rtl/exec_issue.sv
// Execute-stage issue block: E pipeline register feeding the execute unit,
// the condition-code register it feeds back through, and a counter of real
// instructions loaded into E. Optional macro: EXEC_ISSUE_STAT_SQUASH_EN
// (gates CC writes on M/W status being AOK).
module exec_issue
   import y86_pkg::*;
#(
   parameter int W     = 64,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       d_icode,
   input  logic [3:0]       d_ifun,
   input  logic [W-1:0]     d_valC,
   input  logic [W-1:0]     d_valA,
   input  logic [W-1:0]     d_valB,
   input  logic [3:0]       d_dstE,
   input  logic [3:0]       d_dstM,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [2:0]       d_stat,
   input  logic             E_stall,
   input  logic             E_bubble,
   input  logic [2:0]       new_cc,
   input  logic             set_cc,
   input  logic [2:0]       m_stat,
   input  logic [2:0]       W_stat,
   output logic [3:0]       icode,
   output logic [3:0]       ifun,
   output logic [W-1:0]     valC,
   output logic [W-1:0]     valA,
   output logic [W-1:0]     valB,
   output logic [3:0]       E_dstE,
   output logic [3:0]       E_dstM,
   output logic [3:0]       E_srcA,
   output logic [3:0]       E_srcB,
   output logic [2:0]       E_stat,
   output logic             E_valid,
   output logic [2:0]       cc,
   output logic [CNT_W-1:0] issue_cnt
);

   reg_ids_t ids;
   logic     load;

   // Bubble overrides stall; a plain load happens only when neither is asserted
   assign load = ~E_bubble & ~E_stall;

   assign E_dstE = ids.dst_e;
   assign E_dstM = ids.dst_m;
   assign E_srcA = ids.src_a;
   assign E_srcB = ids.src_b;

   // E pipeline register: reset/bubble insert a nop, stall holds, else load decode
   always_ff @(posedge clock) begin
      if (reset || E_bubble) begin
         icode   <= INOP;
         ifun    <= 4'h0;
         valC    <= '0;
         valA    <= '0;
         valB    <= '0;
         ids     <= REG_IDS_NONE;
         E_stat  <= STAT_AOK;
         E_valid <= 1'b0;
      end else if (load) begin
         icode   <= d_icode;
         ifun    <= d_ifun;
         valC    <= d_valC;
         valA    <= d_valA;
         valB    <= d_valB;
         ids     <= '{d_dstE, d_dstM, d_srcA, d_srcB};
         E_stat  <= d_stat;
         E_valid <= 1'b1;
      end
   end

   // Count every real instruction entering E; wraps naturally at 2^CNT_W
   always_ff @(posedge clock) begin
      if (reset)
         issue_cnt <= '0;
      else if (load)
         issue_cnt <= issue_cnt + 1'b1;
   end

   // CC write belongs to the instruction currently held in E, not the incoming one
   cc_reg u_cc_reg (
      .clock   (clock),
      .reset   (reset),
      .set_cc  (set_cc),
      .e_valid (E_valid),
      .new_cc  (new_cc),
      .m_stat  (m_stat),
      .w_stat  (W_stat),
      .cc      (cc)
   );

endmodule

// File: tb/tb_exec_issue.sv
// Directed self-checking bench for exec_issue (CNT_W=4 so wrap is reachable).
module tb_exec_issue;

   localparam int W     = 64;
   localparam int CNT_W = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic [3:0]       d_icode, d_ifun;
   logic [W-1:0]     d_valC, d_valA, d_valB;
   logic [3:0]       d_dstE, d_dstM, d_srcA, d_srcB;
   logic [2:0]       d_stat;
   logic             E_stall, E_bubble;
   logic [2:0]       new_cc;
   logic             set_cc;
   logic [2:0]       m_stat, W_stat;
   logic [3:0]       icode, ifun;
   logic [W-1:0]     valC, valA, valB;
   logic [3:0]       E_dstE, E_dstM, E_srcA, E_srcB;
   logic [2:0]       E_stat;
   logic             E_valid;
   logic [2:0]       cc;
   logic [CNT_W-1:0] issue_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   exec_issue #(.W(W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .d_icode(d_icode), .d_ifun(d_ifun),
      .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
      .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .d_stat(d_stat), .E_stall(E_stall), .E_bubble(E_bubble),
      .new_cc(new_cc), .set_cc(set_cc), .m_stat(m_stat), .W_stat(W_stat),
      .icode(icode), .ifun(ifun), .valC(valC), .valA(valA), .valB(valB),
      .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
      .E_stat(E_stat), .E_valid(E_valid), .cc(cc), .issue_cnt(issue_cnt)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle past it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_d(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] c,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      d_icode = ic; d_ifun = fn; d_valC = c; d_valA = a; d_valB = b;
   endtask

   initial begin
      reset = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
      set_cc = 1'b0; new_cc = 3'b000; m_stat = 3'd1; W_stat = 3'd1;
      drive_d(4'h0, 4'h0, '0, '0, '0);
      d_dstE = 4'h0; d_dstM = 4'h0; d_srcA = 4'h0; d_srcB = 4'h0; d_stat = 3'd1;

      // Reset held two cycles
      step(); step();
      check("rst_icode", icode, 1);
      check("rst_valid", E_valid, 0);
      check("rst_dstE", E_dstE, 4'hF);
      check("rst_dstM", E_dstM, 4'hF);
      check("rst_srcA", E_srcA, 4'hF);
      check("rst_srcB", E_srcB, 4'hF);
      check("rst_stat", E_stat, 1);
      check("rst_cc", cc, 3'b100);
      check("rst_cnt", issue_cnt, 0);

      // First load: OPq subq
      #3;
      reset = 1'b0;
      drive_d(4'h6, 4'h1, 64'h1, 64'h123, 64'h122);
      d_dstE = 4'h3; d_dstM = 4'hF; d_srcA = 4'h2; d_srcB = 4'h3; d_stat = 3'd1;
      step();
      check("ld_icode", icode, 6);
      check("ld_ifun", ifun, 1);
      check("ld_valC", valC, 64'h1);
      check("ld_valA", valA, 64'h123);
      check("ld_valB", valB, 64'h122);
      check("ld_dstE", E_dstE, 4'h3);
      check("ld_srcA", E_srcA, 4'h2);
      check("ld_valid", E_valid, 1);
      check("ld_cnt", issue_cnt, 1);
      check("ld_cc_hold", cc, 3'b100);

      // OPq in E writes CC while E is stalled; d_* changes over 3 stalled cycles
      E_stall = 1'b1; set_cc = 1'b1; new_cc = 3'b010;
      drive_d(4'h2, 4'h0, 64'h5, 64'h999, 64'h888);
      step();
      check("cc_write", cc, 3'b010);
      set_cc = 1'b0;
      drive_d(4'h3, 4'h0, 64'h6, 64'h777, 64'h666);
      step();
      drive_d(4'h5, 4'h0, 64'h7, 64'h555, 64'h444);
      step();
      check("stall_icode", icode, 6);
      check("stall_valA", valA, 64'h123);
      check("stall_valC", valC, 64'h1);
      check("stall_cnt", issue_cnt, 1);

      // Release stall
      E_stall = 1'b0;
      drive_d(4'h2, 4'h0, 64'h0, 64'hAAA, 64'h0);
      d_dstE = 4'h5; d_srcA = 4'h4; d_srcB = 4'hF;
      step();
      check("rel_icode", icode, 2);
      check("rel_valA", valA, 64'hAAA);
      check("rel_dstE", E_dstE, 4'h5);
      check("rel_cnt", issue_cnt, 2);

      // Stall and bubble together: bubble wins, no count
      E_stall = 1'b1; E_bubble = 1'b1;
      step();
      check("bub_icode", icode, 1);
      check("bub_valid", E_valid, 0);
      check("bub_valA", valA, 0);
      check("bub_srcA", E_srcA, 4'hF);
      check("bub_cnt", issue_cnt, 2);

      // Bubble in E requesting a CC write is ignored
      E_bubble = 1'b0; set_cc = 1'b1; new_cc = 3'b111;
      step();
      check("bub_no_cc", cc, 3'b010);

      // Load a real OPq then test the status squash path while holding it
      set_cc = 1'b0; E_stall = 1'b0;
      drive_d(4'h6, 4'h0, 64'h0, 64'h10, 64'h20);
      step();
      check("ld2_cnt", issue_cnt, 3);
      E_stall = 1'b1; set_cc = 1'b1; new_cc = 3'b001; m_stat = 3'd3;
      step();
`ifdef EXEC_ISSUE_STAT_SQUASH_EN
      check("squash_m", cc, 3'b010);
`else
      check("nosquash_m", cc, 3'b001);
`endif
      m_stat = 3'd1; W_stat = 3'd1; new_cc = 3'b001;
      step();
      check("aok_write", cc, 3'b001);

      // Reset mid-stream discards E and the pending CC write
      reset = 1'b1; new_cc = 3'b011;
      step();
      check("mrst_cc", cc, 3'b100);
      check("mrst_icode", icode, 1);
      check("mrst_valid", E_valid, 0);
      check("mrst_cnt", issue_cnt, 0);

      // Counter wrap with CNT_W=4
      reset = 1'b0; set_cc = 1'b0; E_stall = 1'b0;
      for (int i = 0; i < 15; i++) step();
      check("cnt_max", issue_cnt, 4'hF);
      step();
      check("cnt_wrap", issue_cnt, 0);
      check("wrap_valid", E_valid, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exec_issue.md
# exec_issue

Execute-stage issue block for the Y86 pipeline: the E pipeline register that drives `icode/ifun/valC/valA/valB` into the combinational `execute` unit, and the condition-code register that captures `execute`'s `new_cc/set_cc` and feeds `cc` back. It sits between decode and `execute`. It owns stall/bubble handling for E, exception-gated CC writes, and a retired-issue counter.

## Interface
Parameters:
- `W`, 64, datapath width of valC/valA/valB
- `CNT_W`, 32, width of issue counter

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `d_icode, d_ifun`  in  4 each  decoded instruction fields
- `d_valC, d_valA, d_valB`  in  W each  decoded operands
- `d_dstE, d_dstM, d_srcA, d_srcB`  in  4 each  register IDs (4'hF = none)
- `d_stat`  in  3  decode status
- `E_stall`  in  1  hold E register
- `E_bubble`  in  1  load NOP into E register
- `new_cc`  in  3  from execute, {ZF,SF,OF}
- `set_cc`  in  1  from execute, CC write request
- `m_stat, W_stat`  in  3 each  status of instructions in M and W
- `icode, ifun`  out  4 each  to execute
- `valC, valA, valB`  out  W each  to execute
- `E_dstE, E_dstM, E_srcA, E_srcB`  out  4 each  forwarded to hazard/forwarding logic
- `E_stat`  out  3
- `E_valid`  out  1  E holds a real (non-bubble) instruction
- `cc`  out  3  current {ZF,SF,OF} to execute
- `issue_cnt`  out  CNT_W  count of real instructions loaded into E

## Operation
- Stat codes: AOK=1, HLT=2, ADR=3, INS=4.
- Bubble value: icode=4'h1 (nop), ifun=0, valC/valA/valB=0, all reg IDs=4'hF, stat=AOK, E_valid=0.
- Each rising edge, priority: `reset` > `E_bubble` > `E_stall` > load.
  - reset: E register = bubble, `cc`=3'b100 (ZF=1), `issue_cnt`=0.
  - E_bubble (regardless of E_stall): E register = bubble.
  - E_stall only: all E outputs hold.
  - else: load all `d_*` fields; `E_valid`=1.
- `issue_cnt` increments by 1 on each load (not on stall, bubble, or reset); wraps 2^CNT_W-1 → 0.
- CC write: `cc <= new_cc` when `set_cc` and write enable true (see Configuration); otherwise hold. CC write is independent of E_stall/E_bubble for that edge (it belongs to the instruction currently in E).
- `set_cc` with E_valid=0 is ignored (bubbles never write CC).

## Timing
- E register: 1-cycle latency, `d_*` sampled at edge N appear on outputs after edge N.
- CC: OPq in E during cycle N writes `cc` at end of N; instruction in E during N+1 (cmov/jXX) sees the new value. No bubble needed.
- All outputs registered; no combinational path from inputs to outputs.
- Reset mid-stream discards the E instruction and any pending CC write in that cycle.

## Configuration
- `EXEC_ISSUE_STAT_SQUASH_EN` defined: CC write enable = `set_cc & E_valid & m_stat==AOK & W_stat==AOK`; an exception ahead in M or W blocks CC update.
- Undefined: CC write enable = `set_cc & E_valid`; `m_stat`/`W_stat` unused.

## Structure
- Shared package `y86_pkg`: icode constants (INOP=1, IOPQ=6, etc.), stat codes, `REG_NONE`=4'hF, CC bit indices (ZF=2, SF=1, OF=0).
- One sub-module: `cc_reg` (3-bit register, reset 3'b100, gated write with optional squash logic).

## Test plan
- Reset held 2 cycles → icode=1, E_valid=0, dst/src=4'hF, cc=3'b100, issue_cnt=0.
- Load d_icode=6, d_ifun=1, d_valA=0x123, d_valB=0x122, d_valC=1 → next cycle outputs match; issue_cnt=1; set_cc=1, new_cc=3'b010 → cc=3'b010 after following edge.
- E_stall=1 for 3 cycles with changing d_* → outputs and issue_cnt frozen; release → new d_* loaded, issue_cnt+1.
- E_stall=1 and E_bubble=1 same edge → bubble loaded, issue_cnt unchanged.
- With macro: set_cc=1, new_cc=3'b001, m_stat=3 (ADR) → cc holds; same with m_stat=1, W_stat=1 → cc=3'b001. Without macro: first case updates cc.
- Force issue_cnt to all-ones (CNT_W=4 build), load one instruction → issue_cnt=0.
